vga_frame_buffer: RTL and testbench
===================================

# vga_frame_buffer

Parametrised successor to the single-buffer VGA pixel store: a block-RAM frame buffer with optional double buffering, tear-free buffer swap on `frame_trig`, and a hardware fill engine. The bus side writes pixels using the existing `{colour[11:0], y[9:0], x[9:0]}` packed word. The VGA driver side reads scaled-down pixels with one-cycle latency. The block sits between the CPU bus decoder and the VGA timing driver.

## Interface
- `DISPLAY_WIDTH`, 400: stored columns.
- `DISPLAY_HEIGHT`, 300: stored rows.
- `SCALE_SHIFT`, 1: log2 of the upscale factor. Driver and bus coordinates are shifted right by this amount.
- `COLOUR_BITS`, 8: stored bits per pixel. 8 stores RGB332; 12 stores RGB444.
- `DOUBLE_BUFFER`, 1: 1 gives two buffers of DEPTH = W*H entries; 0 gives one buffer.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `x`  in  11  driver pixel column, in native resolution.
- `y`  in  10  driver pixel row, in native resolution.
- `bus_wdata`  in  32  packed word: colour `[31:20]` RGB444, y `[19:10]`, x `[9:0]`.
- `vga_we`  in  1  pixel write strobe, one pixel per cycle.
- `vga_fill`  in  1  start a fill of the back buffer with `bus_wdata[31:20]`.
- `vga_swap`  in  1  request a front/back swap.
- `err_clr`  in  1  clears `wr_dropped`.
- `frame_trig`  in  1  single-cycle vertical-blank pulse from the driver.
- `colour_out`  out  12  RGB444 pixel for the driver.
- `busy`  out  1  fill in progress.
- `swap_pending`  out  1  swap requested but not yet taken.
- `front_buf`  out  1  index of the displayed buffer.
- `wr_dropped`  out  1  sticky flag: at least one pixel write was discarded.

## Operation
**Coordinates**
- Bus pixel: `xw = bus_wdata[9:0] >> SCALE_SHIFT`, `yw = bus_wdata[19:10] >> SCALE_SHIFT`.
- Driver pixel: `xr = x >> SCALE_SHIFT`, `yr = y >> SCALE_SHIFT`.

**Addressing**
- Physical address = `buf*DEPTH + row*DISPLAY_WIDTH + col`, width `$clog2(DEPTH*(1+DOUBLE_BUFFER))`.
- With `DOUBLE_BUFFER=1`: writes and fills target the back buffer (`~front_buf`); reads use `front_buf`.
- With `DOUBLE_BUFFER=0`: everything targets buffer 0, `front_buf` is always 0, `vga_swap` is ignored and `swap_pending` is always 0.

**Colour conversion**
- Write, `COLOUR_BITS=8`: store `{c[11:9], c[7:5], c[3:2]}`.
- Read, `COLOUR_BITS=8`: expand with zero padding: `{s[7:5],0, s[4:2],0, s[1:0],00}`.
- `COLOUR_BITS=12`: stored unchanged in both directions.

**Pixel write**
- A `vga_we` write lands in RAM on that same edge.
- The write is dropped and `wr_dropped` is set when any of these holds:
  - `xw >= DISPLAY_WIDTH`
  - `yw >= DISPLAY_HEIGHT`
  - `busy`
  - `vga_fill` is asserted in the same cycle

**Fill engine (states IDLE, FILL)**
- IDLE -> FILL on `vga_fill`. The colour is latched and the address counter cleared to 0.
- FILL writes one address per cycle, 0 through DEPTH-1, then returns to IDLE.
- `vga_fill` while in FILL is ignored.

**Swap**
- `vga_swap` sets `swap_pending`.
- On the first `frame_trig` in a cycle strictly after the request with `busy=0`: toggle `front_buf` and clear `swap_pending`.
- A `frame_trig` while `busy=1` is skipped; the swap waits for a later trigger.
- Repeated requests while pending have no further effect.

**Read**
- The driver coordinate is looked up in the front buffer.
- If `xr >= W` or `yr >= H`, `colour_out` is 0. The out-of-range flag is pipelined alongside the RAM read.

**Error flag**
- `err_clr` clears `wr_dropped`.
- If a drop happens in the same cycle as `err_clr`, the flag stays set.

## Timing
- Reset (`rst=0` at an edge): `front_buf=0`, `swap_pending=0`, `busy=0`, `wr_dropped=0`, `colour_out=0`, FSM to IDLE, fill counter 0. RAM contents are not cleared.
- Reset during FILL aborts the fill. Addresses already written keep their values.
- Read latency: `x`/`y` presented at edge N gives `colour_out` valid after edge N+1. Full throughput, one pixel per cycle.
- Fill: `vga_fill` sampled at edge N.
  - `busy` goes high after edge N.
  - Address k is written at edge N+1+k.
  - `busy` goes low after edge N+DEPTH.
  - Total DEPTH cycles busy.
- Swap: `front_buf` and `swap_pending` update on the qualifying `frame_trig` edge. The read at that edge already uses the new buffer from the next cycle onward.
- A swap request in the same cycle as `frame_trig` does not swap on that trigger.

## Test plan
Tests 1-4 use W=8, H=4, SHIFT=1, 8-bit colour, double buffering.

1. **Reset state.** Drive `rst=0` for 2 cycles -> all outputs 0 and `busy=0`.
2. **Pixel write, swap, read-back.** Write `bus_wdata={12'hF0C,10'd6,10'd10}`, then `vga_swap`, then `frame_trig`, then drive x=10, y=7 -> `colour_out=12'hE0C` one cycle later. Before the swap, the same coordinate reads the other buffer.
3. **Fill with blocked write.** Pulse `vga_fill` with colour 12'h00F and `vga_we` in the same cycle -> `busy` high exactly 32 cycles and `wr_dropped=1`. After a swap, all 32 pixels read 12'h00C.
4. **Swap deferred by fill.** Issue `vga_swap`, then `vga_fill`, with `frame_trig` pulsed mid-fill and again after the fill -> `front_buf` toggles only on the second trigger and `swap_pending` is 1 between the two.
5. **Out-of-range.** Write x=16 (xw=8) -> dropped and `wr_dropped=1`; `err_clr` -> 0. Read at x=16 -> `colour_out=0`.
6. **Single buffer.** With `DOUBLE_BUFFER=0`, `COLOUR_BITS=12`: a write to 12'hABC is visible one cycle after its read-address cycle. `vga_swap` leaves `front_buf=0` and `swap_pending=0`.

Source files
------------

// File: rtl/vga_frame_buffer.sv
// Block-RAM VGA frame buffer: bus pixel writes, hardware fill, optional double
// buffering with a tear-free swap on frame_trig, one-cycle driver read path.
module vga_frame_buffer #(
    parameter int unsigned DISPLAY_WIDTH  = 400,
    parameter int unsigned DISPLAY_HEIGHT = 300,
    parameter int unsigned SCALE_SHIFT    = 1,
    parameter int unsigned COLOUR_BITS    = 8,
    parameter int unsigned DOUBLE_BUFFER  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [31:0] bus_wdata,
    input  logic        vga_we,
    input  logic        vga_fill,
    input  logic        vga_swap,
    input  logic        err_clr,
    input  logic        frame_trig,
    output logic [11:0] colour_out,
    output logic        busy,
    output logic        swap_pending,
    output logic        front_buf,
    output logic        wr_dropped
);

    localparam int unsigned DEPTH    = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int unsigned NUM_BUFS = (DOUBLE_BUFFER != 0) ? 2 : 1;
    localparam int unsigned TOTAL    = DEPTH * NUM_BUFS;
    localparam int unsigned AW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned CW       = COLOUR_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   fill_cnt;
    logic [AW-1:0]   fill_cnt_next;
    logic [11:0]     fill_colour;
    logic [11:0]     fill_colour_next;

    logic [CW-1:0]   mem [TOTAL];

    // Buffer selection: reads follow front_buf, writes and fills go to the other one.
    logic            back_buf;
    assign back_buf = (DOUBLE_BUFFER != 0) ? ~front_buf : 1'b0;

    // Bus-side coordinates and drop decision
    logic [9:0]      wr_x;
    logic [9:0]      wr_y;
    logic            wr_oor;
    logic            wr_drop;
    logic            bus_wr;
    logic [AW-1:0]   bus_addr;

    assign wr_x    = bus_wdata[9:0] >> SCALE_SHIFT;
    assign wr_y    = bus_wdata[19:10] >> SCALE_SHIFT;
    assign wr_oor  = (32'(wr_x) >= DISPLAY_WIDTH) || (32'(wr_y) >= DISPLAY_HEIGHT);
    assign wr_drop = vga_we && (wr_oor || busy || vga_fill);
    assign bus_wr  = vga_we && !wr_drop;
    assign bus_addr = wr_oor ? '0
                    : AW'(32'(back_buf) * DEPTH + 32'(wr_y) * DISPLAY_WIDTH + 32'(wr_x));

    // Single RAM write port shared by the fill engine and bus writes (mutually exclusive).
    logic [AW-1:0]   fill_addr;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [11:0]     wr_colour;
    logic [CW-1:0]   wr_stored;
    logic            unused_colour_bits;

    assign fill_addr = AW'(32'(back_buf) * DEPTH + 32'(fill_cnt));
    assign ram_we    = rst && (busy || bus_wr);
    assign ram_addr  = busy ? fill_addr : bus_addr;
    assign wr_colour = busy ? fill_colour : bus_wdata[31:20];
    assign wr_stored = (COLOUR_BITS == 8)
                     ? CW'({wr_colour[11:9], wr_colour[7:5], wr_colour[3:2]})
                     : CW'(wr_colour);
    assign unused_colour_bits = ^{wr_colour[8], wr_colour[4], wr_colour[1:0]};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= wr_stored;
        end
    end

    // Driver-side read; the range check is resolved in the same stage as the RAM read.
    logic [10:0]     rd_x;
    logic [9:0]      rd_y;
    logic            rd_oor;
    logic [AW-1:0]   rd_addr;
    logic [CW-1:0]   rd_stored;
    logic [11:0]     rd_colour;

    assign rd_x    = x >> SCALE_SHIFT;
    assign rd_y    = y >> SCALE_SHIFT;
    assign rd_oor  = (32'(rd_x) >= DISPLAY_WIDTH) || (32'(rd_y) >= DISPLAY_HEIGHT);
    assign rd_addr = rd_oor ? '0
                   : AW'(32'(front_buf) * DEPTH + 32'(rd_y) * DISPLAY_WIDTH + 32'(rd_x));
    assign rd_stored = mem[rd_addr];
    assign rd_colour = (COLOUR_BITS == 8)
                     ? {rd_stored[7:5], 1'b0, rd_stored[4:2], 1'b0, rd_stored[1:0], 2'b00}
                     : 12'(rd_stored);

    always_ff @(posedge clk) begin
        if (!rst) begin
            colour_out <= '0;
        end else begin
            colour_out <= rd_oor ? 12'h000 : rd_colour;
        end
    end

    // Fill engine state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            fill_colour <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            fill_cnt    <= fill_cnt_next;
            fill_colour <= fill_colour_next;
            busy        <= (state_next == FILL);
        end
    end

    // Fill engine next-state: sweep 0..DEPTH-1 once, ignore re-triggers while running
    always_comb begin
        state_next       = state;
        fill_cnt_next    = fill_cnt;
        fill_colour_next = fill_colour;
        unique case (state)
            IDLE: begin
                if (vga_fill) begin
                    state_next       = FILL;
                    fill_cnt_next    = '0;
                    fill_colour_next = bus_wdata[31:20];
                end
            end
            FILL: begin
                if (fill_cnt == AW'(DEPTH - 1)) begin
                    state_next    = IDLE;
                    fill_cnt_next = '0;
                end else begin
                    fill_cnt_next = fill_cnt + AW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Swap only on a trigger after the request, and never while the back buffer is being filled.
    logic swap_take;
    logic swap_req;

    assign swap_take = (DOUBLE_BUFFER != 0) && swap_pending && frame_trig && !busy;
    assign swap_req  = (DOUBLE_BUFFER != 0) && vga_swap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            front_buf    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_take) begin
            front_buf    <= ~front_buf;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // A drop in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_dropped <= 1'b0;
        end else if (wr_drop) begin
            wr_dropped <= 1'b1;
        end else if (err_clr) begin
            wr_dropped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Bench for vga_frame_buffer: directed scenarios plus randomized traffic
// against a pixel-array reference model (main: 8x4 RGB332 double, second: 12-bit single).
module tb_vga_frame_buffer;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int DEPTH = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x;
    logic [9:0]  y;
    logic [31:0] bus_wdata;
    logic        vga_we, vga_fill, vga_swap, err_clr, frame_trig;
    logic [11:0] colour_out;
    logic        busy, swap_pending, front_buf, wr_dropped;
    logic [11:0] sb_colour;
    logic        sb_busy, sb_swap_pending, sb_front_buf, sb_wr_dropped;

    int checks = 0;
    int errors = 0;

    logic [11:0] ref_mem [2][DEPTH];
    int          ref_front;
    logic        ref_pending;
    logic        ref_dropped;

    vga_frame_buffer #(
        .DISPLAY_WIDTH(8), .DISPLAY_HEIGHT(4), .SCALE_SHIFT(1),
        .COLOUR_BITS(8), .DOUBLE_BUFFER(1)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .bus_wdata(bus_wdata),
        .vga_we(vga_we), .vga_fill(vga_fill), .vga_swap(vga_swap),
        .err_clr(err_clr), .frame_trig(frame_trig),
        .colour_out(colour_out), .busy(busy), .swap_pending(swap_pending),
        .front_buf(front_buf), .wr_dropped(wr_dropped)
    );

    vga_frame_buffer #(
        .DISPLAY_WIDTH(8), .DISPLAY_HEIGHT(4), .SCALE_SHIFT(1),
        .COLOUR_BITS(12), .DOUBLE_BUFFER(0)
    ) dut_sb (
        .clk(clk), .rst(rst), .x(x), .y(y), .bus_wdata(bus_wdata),
        .vga_we(vga_we), .vga_fill(vga_fill), .vga_swap(vga_swap),
        .err_clr(err_clr), .frame_trig(frame_trig),
        .colour_out(sb_colour), .busy(sb_busy), .swap_pending(sb_swap_pending),
        .front_buf(sb_front_buf), .wr_dropped(sb_wr_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RGB332 storage keeps the top 3/3/2 bits of each channel
    function automatic logic [11:0] seen(input logic [11:0] c);
        return c & 12'hEEC;
    endfunction

    function automatic logic [11:0] ref_read(input int px, input int py);
        int c, r;
        c = px / 2;
        r = py / 2;
        if (c >= W || r >= H) return 12'h000;
        return ref_mem[ref_front][r * W + c];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        x = '0; y = '0; bus_wdata = '0;
        vga_we = 0; vga_fill = 0; vga_swap = 0; err_clr = 0; frame_trig = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({colour_out, busy, swap_pending, front_buf, wr_dropped} !== 16'h0) begin
            errors++;
            $display("FAIL reset_main got %0h exp 0",
                     {colour_out, busy, swap_pending, front_buf, wr_dropped});
        end
        checks++;
        if ({sb_colour, sb_busy, sb_swap_pending, sb_front_buf, sb_wr_dropped} !== 16'h0) begin
            errors++;
            $display("FAIL reset_single got %0h exp 0",
                     {sb_colour, sb_busy, sb_swap_pending, sb_front_buf, sb_wr_dropped});
        end
        rst = 1'b1;
        tick();
        ref_front = 0; ref_pending = 0; ref_dropped = 0;
    endtask

    task automatic test_fill_blocked();
        int n;
        bus_wdata = {12'h00F, 10'd0, 10'd0};
        vga_fill = 1; vga_we = 1;
        tick();
        vga_fill = 0; vga_we = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL fill_busy_cycles got %0d exp %0d", n, DEPTH);
        end
        checks++;
        if (wr_dropped !== 1'b1) begin
            errors++;
            $display("FAIL fill_blocked_write got %0b exp 1", wr_dropped);
        end
        ref_dropped = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[1 - ref_front][i] = seen(12'h00F);
        vga_swap = 1;
        tick();
        vga_swap = 0;
        frame_trig = 1;
        tick();
        frame_trig = 0;
        ref_front = 1 - ref_front;
        checks++;
        if (front_buf !== 1'(ref_front) || swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL fill_swap got front %0b pend %0b exp front %0d pend 0",
                     front_buf, swap_pending, ref_front);
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                x = 11'(2 * c + int'($urandom_range(0, 1)));
                y = 10'(2 * r + int'($urandom_range(0, 1)));
                tick();
                checks++;
                if (colour_out !== 12'h00C) begin
                    errors++;
                    $display("FAIL fill_readback r%0d c%0d got %h exp 00c", r, c, colour_out);
                end
            end
        end
    endtask

    task automatic test_swap_deferred();
        logic [11:0] c;
        int          n;
        logic [11:0] exp;
        int          px, py;
        vga_swap = 1;
        tick();
        vga_swap = 0;
        checks++;
        if (swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL defer_pending_set got %0b exp 1", swap_pending);
        end
        c = 12'($urandom);
        bus_wdata = {c, 20'($urandom)};
        vga_fill = 1;
        tick();
        vga_fill = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL defer_busy got %0b exp 1", busy);
        end
        repeat (10) tick();
        frame_trig = 1;
        tick();
        frame_trig = 0;
        checks++;
        if (front_buf !== 1'(ref_front) || swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL defer_mid_fill got front %0b pend %0b exp front %0d pend 1",
                     front_buf, swap_pending, ref_front);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (busy !== 1'b0 || swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL defer_after_fill got busy %0b pend %0b exp busy 0 pend 1",
                     busy, swap_pending);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[1 - ref_front][i] = seen(c);
        frame_trig = 1;
        tick();
        frame_trig = 0;
        ref_front = 1 - ref_front;
        checks++;
        if (front_buf !== 1'(ref_front) || swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL defer_second_trig got front %0b pend %0b exp front %0d pend 0",
                     front_buf, swap_pending, ref_front);
        end
        for (int i = 0; i < 4; i++) begin
            px = int'($urandom_range(0, 15));
            py = int'($urandom_range(0, 7));
            exp = ref_read(px, py);
            x = 11'(px); y = 10'(py);
            tick();
            checks++;
            if (colour_out !== exp) begin
                errors++;
                $display("FAIL defer_readback (%0d,%0d) got %h exp %h", px, py, colour_out, exp);
            end
        end
    endtask

    task automatic test_write_swap_read();
        logic [11:0] exp;
        bus_wdata = {12'hF0C, 10'd6, 10'd10};
        vga_we = 1;
        tick();
        vga_we = 0;
        ref_mem[1 - ref_front][3 * W + 5] = seen(12'hF0C);
        x = 11'd10; y = 10'd7;
        exp = ref_read(10, 7);
        tick();
        checks++;
        if (colour_out !== exp) begin
            errors++;
            $display("FAIL pre_swap_read got %h exp %h", colour_out, exp);
        end
        vga_swap = 1;
        tick();
        vga_swap = 0;
        frame_trig = 1;
        tick();
        frame_trig = 0;
        ref_front = 1 - ref_front;
        tick();
        checks++;
        if (colour_out !== 12'hE0C) begin
            errors++;
            $display("FAIL post_swap_read got %h exp e0c", colour_out);
        end
    endtask

    task automatic test_out_of_range();
        err_clr = 1;
        tick();
        err_clr = 0;
        checks++;
        if (wr_dropped !== 1'b0) begin
            errors++;
            $display("FAIL oor_initial_clear got %0b exp 0", wr_dropped);
        end
        bus_wdata = {12'h123, 10'd0, 10'd16};
        vga_we = 1;
        tick();
        vga_we = 0;
        checks++;
        if (wr_dropped !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_drop got %0b exp 1", wr_dropped);
        end
        bus_wdata = {12'h123, 10'd8, 10'd2};
        vga_we = 1; err_clr = 1;
        tick();
        vga_we = 0;
        checks++;
        if (wr_dropped !== 1'b1) begin
            errors++;
            $display("FAIL oor_drop_with_clear got %0b exp 1", wr_dropped);
        end
        tick();
        err_clr = 0;
        checks++;
        if (wr_dropped !== 1'b0) begin
            errors++;
            $display("FAIL oor_clear got %0b exp 0", wr_dropped);
        end
        ref_dropped = 0;
        x = 11'd16; y = 10'd2;
        tick();
        checks++;
        if (colour_out !== 12'h000) begin
            errors++;
            $display("FAIL oor_read_x got %h exp 000", colour_out);
        end
        x = 11'd4; y = 10'd8;
        tick();
        checks++;
        if (colour_out !== 12'h000) begin
            errors++;
            $display("FAIL oor_read_y got %h exp 000", colour_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_col;
        logic [11:0] wc;
        int wx, wy, rx, ry, col, row;
        logic drop;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            vga_we     = ($urandom_range(0, 1) == 1);
            wx         = int'($urandom_range(0, 19));
            wy         = int'($urandom_range(0, 9));
            wc         = 12'($urandom);
            bus_wdata  = {wc, 10'(wy), 10'(wx)};
            vga_swap   = ($urandom_range(0, 7) == 0);
            frame_trig = ($urandom_range(0, 3) == 0);
            err_clr    = ($urandom_range(0, 7) == 0);
            rx         = int'($urandom_range(0, 19));
            ry         = int'($urandom_range(0, 9));
            x = 11'(rx); y = 10'(ry);
            exp_col = ref_read(rx, ry);
            drop = 0;
            if (vga_we) begin
                col = wx / 2;
                row = wy / 2;
                if (col < W && row < H) ref_mem[1 - ref_front][row * W + col] = seen(wc);
                else drop = 1;
            end
            if (drop) ref_dropped = 1;
            else if (err_clr) ref_dropped = 0;
            if (ref_pending && frame_trig) begin
                ref_front = 1 - ref_front;
                ref_pending = 0;
            end else if (vga_swap) begin
                ref_pending = 1;
            end
            tick();
            checks++;
            if (colour_out !== exp_col) begin
                errors++;
                $display("FAIL rand_colour it%0d (%0d,%0d) got %h exp %h", i, rx, ry, colour_out, exp_col);
            end
            checks++;
            if (front_buf !== 1'(ref_front) || swap_pending !== ref_pending) begin
                errors++;
                $display("FAIL rand_swap it%0d got front %0b pend %0b exp front %0d pend %0b",
                         i, front_buf, swap_pending, ref_front, ref_pending);
            end
            checks++;
            if (wr_dropped !== ref_dropped) begin
                errors++;
                $display("FAIL rand_dropped it%0d got %0b exp %0b", i, wr_dropped, ref_dropped);
            end
        end
        idle_inputs();
    endtask

    task automatic test_single_buffer();
        idle_inputs();
        bus_wdata = {12'hABC, 10'd2, 10'd4};
        vga_we = 1;
        x = 11'd4; y = 10'd2;
        tick();
        vga_we = 0;
        tick();
        checks++;
        if (sb_colour !== 12'hABC) begin
            errors++;
            $display("FAIL single_readback got %h exp abc", sb_colour);
        end
        vga_swap = 1;
        tick();
        vga_swap = 0;
        frame_trig = 1;
        tick();
        frame_trig = 0;
        tick();
        checks++;
        if (sb_front_buf !== 1'b0 || sb_swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL single_swap_ignored got front %0b pend %0b exp 0 0",
                     sb_front_buf, sb_swap_pending);
        end
        checks++;
        if (sb_colour !== 12'hABC) begin
            errors++;
            $display("FAIL single_after_swap got %h exp abc", sb_colour);
        end
        x = 11'd16;
        tick();
        checks++;
        if (sb_colour !== 12'h000) begin
            errors++;
            $display("FAIL single_oor_read got %h exp 000", sb_colour);
        end
    endtask

    initial begin
        test_reset();
        test_fill_blocked();
        test_swap_deferred();
        test_write_swap_read();
        test_out_of_range();
        test_back_to_back();
        test_single_buffer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
